// File: rtl/fs_pkg.sv
// fs_pkg: shared types and elaboration helpers for the serial subtractor.
//   fs_seq_state_t : controller state encoding
//   fs_nchunk      : number of chunk slices per operand
//   fs_chunk_ok    : divisibility / sanity check on width vs chunk
//   fs_cnt_width   : chunk counter width (never zero bits)
package fs_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } fs_seq_state_t;

   function automatic int fs_nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   function automatic bit fs_chunk_ok(input int width, input int chunk);
      return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
   endfunction

   function automatic int fs_cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fs_chunk_sub.sv
// fs_chunk_sub: combinational CHUNK_WIDTH-bit subtractor slice.
//   a, b  : chunk operands
//   cin   : borrow-in
//   out   : a - b - cin (mod 2^CHUNK_WIDTH)
//   cout  : borrow-out (MSB of the C+1-bit difference)
module fs_chunk_sub #(
   parameter int CHUNK_WIDTH = 8
) (
   input  logic [CHUNK_WIDTH-1:0] a,
   input  logic [CHUNK_WIDTH-1:0] b,
   input  logic                   cin,
   output logic [CHUNK_WIDTH-1:0] out,
   output logic                   cout
);

   assign {cout, out} = {1'b0, a} - {1'b0, b} - {{CHUNK_WIDTH{1'b0}}, cin};

endmodule

// File: rtl/fs_seq_sub.sv
// fs_seq_sub: serial a - b - cin using one CHUNK_WIDTH slice, LSB chunk
// first, with a registered borrow chain and valid/ready on both sides.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : operand handshake (a, b, cin)
//   out_valid/out_ready  : result handshake (out, cout[, zero])
//   cout                 : borrow-out, 1 iff a < b + cin (unsigned)
//   zero                 : result-is-zero flag, only with FS_SEQ_SUB_ZERO_EN
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// BUSY  | one chunk per cycle, counter selects the slice
// DONE  | result held with out_valid=1 until out_ready
module fs_seq_sub
   import fs_pkg::*;
#(
   parameter int DATA_WIDTH  = 24,
   parameter int CHUNK_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  cin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out,
`ifdef FS_SEQ_SUB_ZERO_EN
   output logic                  cout,
   output logic                  zero
`else
   output logic                  cout
`endif
);

   localparam int NCHUNK = fs_nchunk(DATA_WIDTH, CHUNK_WIDTH);
   localparam int CNT_W  = fs_cnt_width(NCHUNK);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

   generate
      if (!fs_chunk_ok(DATA_WIDTH, CHUNK_WIDTH)) begin : g_bad_chunk
         $error("fs_seq_sub: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
      end
   endgenerate

   fs_seq_state_t           state_q, state_nxt;
   logic [CNT_W-1:0]        cnt_q;
   logic [DATA_WIDTH-1:0]   a_q, b_q, out_q;
   logic                    borrow_q, cout_q;
   logic [CHUNK_WIDTH-1:0]  a_k, b_k, diff_k;
   logic                    borrow_k;
   logic                    accept, last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
      accept    = in_valid && in_ready;
      last      = (cnt_q == LAST);
      case (state_q)
         IDLE: if (accept) state_nxt = BUSY;
         BUSY: if (last) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // slice operand select; constant-index compare keeps every part-select static
   always_comb begin
      a_k = '0;
      b_k = '0;
      for (int k = 0; k < NCHUNK; k++) begin
         if (cnt_q == CNT_W'(k)) begin
            a_k = a_q[k*CHUNK_WIDTH +: CHUNK_WIDTH];
            b_k = b_q[k*CHUNK_WIDTH +: CHUNK_WIDTH];
         end
      end
   end

   fs_chunk_sub #(.CHUNK_WIDTH(CHUNK_WIDTH)) u_slice (
      .a    (a_k),
      .b    (b_k),
      .cin  (borrow_q),
      .out  (diff_k),
      .cout (borrow_k)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         borrow_q <= 1'b0;
         out_q    <= '0;
         cout_q   <= 1'b0;
      end else if (accept) begin
         cnt_q    <= '0;
         a_q      <= a;
         b_q      <= b;
         borrow_q <= cin;
      end else if (state_q == BUSY) begin
         for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CNT_W'(k)) out_q[k*CHUNK_WIDTH +: CHUNK_WIDTH] <= diff_k;
         end
         borrow_q <= borrow_k;
         cout_q   <= borrow_k;
         if (!last) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign out_valid = (state_q == DONE);
   assign out       = out_q;
   assign cout      = cout_q;

`ifdef FS_SEQ_SUB_ZERO_EN
   logic zero_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 zero_acc <= 1'b0;
      else if (accept)            zero_acc <= 1'b1;
      else if (state_q == BUSY)   zero_acc <= zero_acc && (diff_k == '0);
   end

   assign zero = out_valid && zero_acc;
`endif

endmodule

// File: tb/tb_fs_seq_sub.sv
// tb_fs_seq_sub: directed plus randomized bench for fs_seq_sub. Three
// instances (24/8, 32/8, 16/16) share clock, reset and operand buses; the
// active configuration gets the handshakes, the others stay idle.
module tb_fs_seq_sub;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [2:0]  iv, orr, ir, ov, co;
   logic [31:0] ai, bi;
   logic        ci;
   logic [23:0] o0;
   logic [31:0] o1;
   logic [15:0] o2;
`ifdef FS_SEQ_SUB_ZERO_EN
   logic [2:0]  zz;
`endif

   int cfg = 0;
   int checks = 0;
   int failures = 0;
   int w_of[3] = '{24, 32, 16};
   int n_of[3] = '{3, 4, 1};

   logic [31:0] exp_out;
   logic        exp_cout;
   logic        exp_zero;

   fs_seq_sub #(.DATA_WIDTH(24), .CHUNK_WIDTH(8)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
      .a(ai[23:0]), .b(bi[23:0]), .cin(ci), .out_valid(ov[0]),
      .out_ready(orr[0]), .out(o0),
`ifdef FS_SEQ_SUB_ZERO_EN
      .zero(zz[0]),
`endif
      .cout(co[0]));

   fs_seq_sub #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
      .a(ai), .b(bi), .cin(ci), .out_valid(ov[1]),
      .out_ready(orr[1]), .out(o1),
`ifdef FS_SEQ_SUB_ZERO_EN
      .zero(zz[1]),
`endif
      .cout(co[1]));

   fs_seq_sub #(.DATA_WIDTH(16), .CHUNK_WIDTH(16)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
      .a(ai[15:0]), .b(bi[15:0]), .cin(ci), .out_valid(ov[2]),
      .out_ready(orr[2]), .out(o2),
`ifdef FS_SEQ_SUB_ZERO_EN
      .zero(zz[2]),
`endif
      .cout(co[2]));

   logic [31:0] obs_out;
   always_comb begin
      case (cfg)
         0:       obs_out = {8'h00, o0};
         1:       obs_out = o1;
         default: obs_out = {16'h0000, o2};
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s cfg=%0d observed=%0h expected=%0h", tag, cfg, obs, expv);
      end
   endtask

   // Reference: plain integer arithmetic on width-masked operands.
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic c);
      longint mask, am, bm, d;
      mask = (64'd1 << w_of[cfg]) - 1;
      am = longint'(a) & mask;
      bm = longint'(b) & mask;
      d  = am - bm - longint'(c);
      exp_out  = 32'(d & mask);
      exp_cout = (am < bm + longint'(c));
      exp_zero = (exp_out == 32'd0);
   endtask

   task automatic check_result();
      chk("out_valid", ov[cfg], 1);
      chk("out", obs_out, exp_out);
      chk("cout", co[cfg], exp_cout);
`ifdef FS_SEQ_SUB_ZERO_EN
      chk("zero", zz[cfg], exp_zero);
`endif
   endtask

   task automatic do_reset();
      iv = '0; orr = '0; ai = '0; bi = '0; ci = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("rst_out_valid", ov[cfg], 0);
      chk("rst_out", obs_out, 0);
      chk("rst_cout", co[cfg], 0);
      chk("rst_in_ready", ir[cfg], 1);
`ifdef FS_SEQ_SUB_ZERO_EN
      chk("rst_zero", zz[cfg], 0);
`endif
   endtask

   // Presents operands and completes the accept edge; caller sets out_ready.
   task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic c);
      ai = a; bi = b; ci = c;
      iv[cfg] = 1'b1;
      #1 chk("in_ready_accept", ir[cfg], 1);
      @(posedge clk);
      #1 iv[cfg] = 1'b0;
      model(a, b, c);
      chk("valid_low_busy", ov[cfg], 0);
   endtask

   task automatic wait_result(input int n0);
      int n;
      n = n0;
      while (ov[cfg] !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      chk("latency", n, n_of[cfg]);
      check_result();
   endtask

   task automatic hold(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         check_result();
         chk("hold_in_ready", ir[cfg], 0);
      end
   endtask

   task automatic consume();
      orr[cfg] = 1'b1;
      #1 chk("in_ready_done", ir[cfg], 1);
      @(posedge clk);
      #1 orr[cfg] = 1'b0;
      chk("valid_drop", ov[cfg], 0);
      chk("idle_in_ready", ir[cfg], 1);
   endtask

   task automatic simple_op(input logic [31:0] a, input logic [31:0] b, input logic c);
      drive_op(a, b, c);
      wait_result(0);
      consume();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout cfg=%0d", cfg);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      logic        rc;
      bit          pending;

      for (int c = 0; c < 3; c++) begin
         cfg = c;
         do_reset();

         simple_op(32'h0000_0100, 32'h0000_0001, 1'b0);
         simple_op(32'h0000_0000, 32'h0000_0000, 1'b1);
         simple_op(32'h0012_3456, 32'h0012_3456, 1'b0);
         simple_op(32'h0080_0000, 32'h007F_FFFF, 1'b0);

         // backpressure with an ignored in_valid pulse during BUSY
         drive_op(32'h00AB_CDEF, 32'h0001_2345, 1'b1);
         ai = 32'hFFFF_FFFF; bi = 32'h0; ci = 1'b0;
         iv[cfg] = 1'b1;
         @(posedge clk);
         #1 iv[cfg] = 1'b0;
         wait_result(1);
         hold(5);

         // back-to-back accept from DONE
         orr[cfg] = 1'b1;
         drive_op(32'h0000_55AA, 32'h0000_AA55, 1'b0);
         orr[cfg] = 1'b0;
         wait_result(0);
         consume();

         // asynchronous reset in the middle of an operation
         drive_op(32'h00FF_FFFF, 32'h0000_0001, 1'b0);
         @(posedge clk);
         #2 rst_n = 1'b0;
         #1;
         chk("midrst_out_valid", ov[cfg], 0);
         chk("midrst_out", obs_out, 0);
         chk("midrst_in_ready", ir[cfg], 1);
         #3 rst_n = 1'b1;
         @(posedge clk);
         #1;
         chk("postrst_out_valid", ov[cfg], 0);
         chk("postrst_in_ready", ir[cfg], 1);
         simple_op(32'd5, 32'd3, 1'b0);

         // randomized traffic with random stalls and back-to-back accepts
         pending = 1'b0;
         for (int i = 0; i < 15; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            rc = 1'($urandom_range(0, 1));
            if (pending && ($urandom_range(0, 1) == 1)) begin
               orr[cfg] = 1'b1;
               drive_op(ra, rb, rc);
               orr[cfg] = 1'b0;
            end else begin
               if (pending) consume();
               drive_op(ra, rb, rc);
            end
            wait_result(0);
            hold($urandom_range(0, 2));
            pending = 1'b1;
         end
         if (pending) consume();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
